// File: rtl/clock_monitor.sv
// clock_monitor: measures three derived clocks against expected periods and runs an ACQUIRE/LOCKED/FAULT supervisor.
// Optional CLKMON_PHASE_CHECK_EN adds processor-to-regfile edge offset checking (fault_src[3]).
`default_nettype none

module clock_monitor #(
    parameter int IMEM_PERIOD = 2,
    parameter int PROC_PERIOD = 4,
    parameter int REG_PERIOD  = 4,
    parameter int LOCK_COUNT  = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             imem_clock,
    input  logic             processor_clock,
    input  logic             regfile_clock,
    input  logic             clear_fault,
    output logic             locked,
    output logic             fault,
    output logic [3:0]       fault_src,
    output logic [CNT_W-1:0] imem_period,
    output logic [CNT_W-1:0] proc_period,
    output logic [CNT_W-1:0] reg_period,
    output logic             meas_valid
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam int               STREAK_W = $clog2(LOCK_COUNT + 1) + 1;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        LOCKED  = 2'd1,
        FAULT   = 2'd2
    } state_t;

    state_t              state;
    logic [STREAK_W-1:0] streak;

    // Channel index: 0 = imem, 1 = processor, 2 = regfile
    logic [2:0]       raw;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       hist;
    logic [2:0]       edge_det;
    logic [2:0]       armed;
    logic [CNT_W-1:0] cnt   [3];
    logic [CNT_W-1:0] per_q [3];

    assign raw      = {regfile_clock, processor_clock, imem_clock};
    assign edge_det = sync2 & ~hist;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1      <= '0;
            sync2      <= '0;
            hist       <= '0;
            armed      <= '0;
            meas_valid <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt[i]   <= '0;
                per_q[i] <= '0;
            end
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            hist       <= sync2;
            meas_valid <= edge_det[1] & armed[1];
            for (int i = 0; i < 3; i++) begin
                if (edge_det[i]) begin
                    cnt[i]   <= CNT_W'(1);
                    armed[i] <= 1'b1;
                    if (armed[i]) begin
                        per_q[i] <= cnt[i];
                    end
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign imem_period = per_q[0];
    assign proc_period = per_q[1];
    assign reg_period  = per_q[2];

    logic [2:0] mism_raw;
    logic [2:0] stall;
    logic       match;
    logic       phase_err;
    logic [3:0] err;

    assign mism_raw[0] = (per_q[0] != CNT_W'(IMEM_PERIOD));
    assign mism_raw[1] = (per_q[1] != CNT_W'(PROC_PERIOD));
    assign mism_raw[2] = (per_q[2] != CNT_W'(REG_PERIOD));
    assign stall[0]    = (cnt[0] == CNT_MAX);
    assign stall[1]    = (cnt[1] == CNT_MAX);
    assign stall[2]    = (cnt[2] == CNT_MAX);
    assign match       = meas_valid & (&armed) & ~(|mism_raw);
    assign err         = {phase_err, (meas_valid ? mism_raw : 3'b000) | stall};

`ifdef CLKMON_PHASE_CHECK_EN
    logic [CNT_W-1:0] ph_cnt;
    logic [CNT_W-1:0] ref_off;
    logic             pending;
    logic             ref_valid;
    logic             off_valid;
    logic [CNT_W-1:0] off_val;

    // Only the first regfile edge following a processor edge yields an offset.
    assign off_valid = edge_det[2] & (edge_det[1] | pending);
    assign off_val   = edge_det[1] ? '0 : ph_cnt;
    assign phase_err = (state != ACQUIRE) & ref_valid & off_valid & (off_val != ref_off);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ph_cnt    <= '0;
            ref_off   <= '0;
            pending   <= 1'b0;
            ref_valid <= 1'b0;
        end else begin
            if (edge_det[1]) begin
                ph_cnt  <= CNT_W'(1);
                pending <= ~edge_det[2];
            end else begin
                if (ph_cnt != CNT_MAX) begin
                    ph_cnt <= ph_cnt + CNT_W'(1);
                end
                if (edge_det[2]) begin
                    pending <= 1'b0;
                end
            end
            if (state == ACQUIRE) begin
                ref_valid <= 1'b0;
            end else if (state == LOCKED && off_valid && !ref_valid) begin
                ref_off   <= off_val;
                ref_valid <= 1'b1;
            end
        end
    end
`else
    assign phase_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ACQUIRE;
            streak    <= '0;
            locked    <= 1'b0;
            fault     <= 1'b0;
            fault_src <= '0;
        end else begin
            case (state)
                ACQUIRE: begin
                    if (streak == STREAK_W'(LOCK_COUNT)) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end else if (meas_valid) begin
                        streak <= match ? streak + STREAK_W'(1) : '0;
                    end
                end
                LOCKED: begin
                    if (|err) begin
                        state     <= FAULT;
                        locked    <= 1'b0;
                        fault     <= 1'b1;
                        fault_src <= err;
                    end
                end
                FAULT: begin
                    // A clear in the same cycle as a new error wins; that error is dropped.
                    if (clear_fault) begin
                        state     <= ACQUIRE;
                        fault     <= 1'b0;
                        fault_src <= '0;
                        streak    <= '0;
                    end else begin
                        fault_src <= fault_src | err;
                    end
                end
                default: begin
                    state     <= ACQUIRE;
                    locked    <= 1'b0;
                    fault     <= 1'b0;
                    fault_src <= '0;
                    streak    <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: scoreboard bench for clock_monitor; expected status records are queued with each stimulus step.
`default_nettype none

module tb_clock_monitor;

    logic       clock;
    logic       reset;
    logic       imem_clock;
    logic       processor_clock;
    logic       regfile_clock;
    logic       clear_fault;
    logic       locked;
    logic       fault;
    logic [3:0] fault_src;
    logic [7:0] imem_period;
    logic [7:0] proc_period;
    logic [7:0] reg_period;
    logic       meas_valid;

    clock_monitor dut (
        .clock           (clock),
        .reset           (reset),
        .imem_clock      (imem_clock),
        .processor_clock (processor_clock),
        .regfile_clock   (regfile_clock),
        .clear_fault     (clear_fault),
        .locked          (locked),
        .fault           (fault),
        .fault_src       (fault_src),
        .imem_period     (imem_period),
        .proc_period     (proc_period),
        .reg_period      (reg_period),
        .meas_valid      (meas_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic       lk;
        logic       ft;
        logic [3:0] src;
        logic       chk_per;
        logic [7:0] ip;
        logic [7:0] pp;
        logic [7:0] rp;
    } exp_t;

    exp_t  sb[$];
    string sb_tag[$];

    task automatic push_exp(input string tag, input logic lk, input logic ft, input logic [3:0] src,
                            input logic chk_per, input logic [7:0] ip, input logic [7:0] pp, input logic [7:0] rp);
        exp_t e;
        e = '{lk: lk, ft: ft, src: src, chk_per: chk_per, ip: ip, pp: pp, rp: rp};
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    task automatic sb_compare();
        exp_t  e;
        string t;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            t = sb_tag.pop_front();
            check({t, ".locked"}, locked, e.lk);
            check({t, ".fault"}, fault, e.ft);
            check({t, ".fault_src"}, fault_src, e.src);
            if (e.chk_per) begin
                check({t, ".imem_period"}, imem_period, e.ip);
                check({t, ".proc_period"}, proc_period, e.pp);
                check({t, ".reg_period"}, reg_period, e.rp);
            end
        end
    endtask

    // Derived-clock generator, driven on the falling master edge
    bit gen_en = 0;
    int tick = 0;
    int imem_per = 2, proc_per = 4, reg_per = 4, reg_shift = 0;
    bit imem_hold = 0, proc_hold = 0;

    initial begin
        imem_clock      = 1'b0;
        processor_clock = 1'b0;
        regfile_clock   = 1'b0;
        forever begin
            @(negedge clock);
            if (gen_en) begin
                imem_clock      = !imem_hold && ((tick % imem_per) < imem_per / 2);
                processor_clock = !proc_hold && ((tick % proc_per) < proc_per / 2);
                regfile_clock   = ((tick + reg_per - reg_shift) % reg_per) < reg_per / 2;
                tick++;
            end
        end
    end

    task automatic align8();
        do @(posedge clock); while (tick % 8 != 0);
    endtask

    task automatic wait_lock(output int nmv, output bit ok);
        nmv = 0;
        ok  = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clock); #1;
            if (meas_valid) nmv++;
            if (locked) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_fault(output int n, output bit ok);
        n  = 0;
        ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clock); #1;
            n++;
            if (fault) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        clear_fault = 1'b1;
        @(negedge clock);
        clear_fault = 1'b0;
        @(posedge clock); #1;
    endtask

    int nmv;
    int n;
    bit ok;
    int bad;

    initial begin
        reset       = 1'b0;
        clear_fault = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        push_exp("reset", 0, 0, 4'b0000, 1, 8'd0, 8'd0, 8'd0);
        sb_compare();
        check("reset.meas_valid", meas_valid, 0);

        @(negedge clock); #1 reset = 1'b1;
        @(posedge clock);
        tick   = 0;
        gen_en = 1;
        wait_lock(nmv, ok);
        check("lock1.reached", ok, 1);
        check("lock1.rounds", nmv, 4);
        push_exp("lock1", 1, 0, 4'b0000, 1, 8'd2, 8'd4, 8'd4);
        sb_compare();

        bad = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (fault || !locked) bad++;
        end
        check("steady.bad_cycles", bad, 0);

        pulse_clear();
        push_exp("clear_in_locked", 1, 0, 4'b0000, 1, 8'd2, 8'd4, 8'd4);
        sb_compare();

        // Processor clock stalls low
        align8();
        proc_hold = 1;
        push_exp("proc_stall", 0, 1, 4'b0010, 1, 8'd2, 8'd4, 8'd4);
        wait_fault(n, ok);
        check("proc_stall.reached", ok, 1);
        sb_compare();
        check("proc_stall.latency_ok", (n >= 240 && n <= 270), 1);
        align8();
        proc_hold = 0;
        pulse_clear();
        push_exp("proc_stall.cleared", 0, 0, 4'b0000, 0, 8'd0, 8'd0, 8'd0);
        sb_compare();
        wait_lock(nmv, ok);
        check("lock2.reached", ok, 1);
        push_exp("lock2", 1, 0, 4'b0000, 1, 8'd2, 8'd4, 8'd4);
        sb_compare();

        // Regfile clock slows to period 8
        align8();
        reg_per = 8;
        push_exp("reg_slow", 0, 1, 4'b0100, 1, 8'd2, 8'd4, 8'd8);
        wait_fault(n, ok);
        check("reg_slow.reached", ok, 1);
        sb_compare();
        pulse_clear();
        push_exp("reg_slow.cleared", 0, 0, 4'b0000, 0, 8'd0, 8'd0, 8'd0);
        sb_compare();
        align8();
        reg_per = 4;
        wait_lock(nmv, ok);
        check("lock3.reached", ok, 1);
        push_exp("lock3", 1, 0, 4'b0000, 1, 8'd2, 8'd4, 8'd4);
        sb_compare();

        // imem stall, then clear while the stall error is still active
        align8();
        imem_hold = 1;
        push_exp("imem_stall", 0, 1, 4'b0001, 1, 8'd2, 8'd4, 8'd4);
        wait_fault(n, ok);
        check("imem_stall.reached", ok, 1);
        sb_compare();
        pulse_clear();
        push_exp("imem_stall.cleared", 0, 0, 4'b0000, 1, 8'd2, 8'd4, 8'd4);
        sb_compare();
        repeat (10) @(posedge clock);
        #1;
        push_exp("imem_stall.acquire", 0, 0, 4'b0000, 0, 8'd0, 8'd0, 8'd0);
        sb_compare();
        align8();
        imem_hold = 0;
        wait_lock(nmv, ok);
        check("lock4.reached", ok, 1);
        push_exp("lock4", 1, 0, 4'b0000, 1, 8'd2, 8'd4, 8'd4);
        sb_compare();

        // Asynchronous reset while locked
        repeat (3) @(posedge clock);
        @(negedge clock); #1 reset = 1'b0;
        #1;
        push_exp("async_reset", 0, 0, 4'b0000, 1, 8'd0, 8'd0, 8'd0);
        sb_compare();
        check("async_reset.meas_valid", meas_valid, 0);
        repeat (3) @(posedge clock);
        do @(posedge clock); while (tick % 8 != 3);
        @(negedge clock); #1 reset = 1'b1;
        wait_lock(nmv, ok);
        check("relock.reached", ok, 1);
        check("relock.rounds", nmv, 4);
        push_exp("relock", 1, 0, 4'b0000, 1, 8'd2, 8'd4, 8'd4);
        sb_compare();

`ifdef CLKMON_PHASE_CHECK_EN
        repeat (20) @(posedge clock);
        align8();
        reg_shift = 1;
        push_exp("phase_shift", 0, 1, 4'b1000, 0, 8'd0, 8'd0, 8'd0);
        wait_fault(n, ok);
        check("phase_shift.reached", ok, 1);
        sb_compare();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
